// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER data-memory port arbiter.
package otter_mem_pkg;

  // Access width as seen on the memory SIZE pins.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  // Addresses at or above this go to memory-mapped IO; the arbiter treats them like RAM.
  localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

  // One requester's access attributes, bundled for muxing.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    mem_size_t   size;
    logic        sign;
  } mem_req_t;

  // IDLE arbitrates; RD_DATA is the single data-return cycle of a load.
  typedef enum logic {
    IDLE    = 1'b0,
    RD_DATA = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_prio_arb.sv
// Fixed-priority (M0) arbiter with a starvation counter that lets M1 win
// after MAX_WAIT consecutive lost requests.
module dmem_prio_arb #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic arb_en_i,
  input  logic m0_req_i,
  input  logic m1_req_i,
  output logic m0_gnt_o,
  output logic m1_gnt_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  // Winner selection and starvation-counter next state; the counter only moves while arbitrating.
  always_comb begin
    m1_gnt_o   = arb_en_i && m1_req_i && (!m0_req_i || (wait_cnt_q == WAIT_MAX));
    m0_gnt_o   = arb_en_i && m0_req_i && !m1_gnt_o;
    wait_cnt_d = wait_cnt_q;
    if (arb_en_i) begin
      if (!m1_req_i || m1_gnt_o) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + CW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (srst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Two-master arbiter for the OTTER data-memory port. Stores complete in the
// grant cycle; loads hold address/size/sign for one extra cycle because the
// memory sizes and sign-extends DOUT2 from them combinationally.
module otter_dmem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_DIN,
  input  logic [1:0]  M0_SIZE,
  input  logic        M0_SIGN,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_DIN,
  input  logic [1:0]  M1_SIZE,
  input  logic        M1_SIGN,
  output logic        M0_GNT,
  output logic        M1_GNT,
  output logic        M0_RVALID,
  output logic        M1_RVALID,
  output logic [31:0] M0_RDATA,
  output logic [31:0] M1_RDATA,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  mem_req_t   m0_req, m1_req, sel_req;
  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;   // 1 = M1 owns the outstanding load
  logic [31:0] addr_q, addr_d;
  mem_size_t  size_q, size_d;
  logic       sign_q, sign_d;
  logic       arb_en, gnt0, gnt1;
  logic       rvalid_q [2];
  logic [31:0] rdata_q [2];

  assign m0_req = '{we: M0_WE, addr: M0_ADDR, din: M0_DIN, size: mem_size_t'(M0_SIZE), sign: M0_SIGN};
  assign m1_req = '{we: M1_WE, addr: M1_ADDR, din: M1_DIN, size: mem_size_t'(M1_SIZE), sign: M1_SIGN};

  // Arbitration only happens in IDLE and never while reset is asserted.
  assign arb_en = (state_q == IDLE) && !RST;

  dmem_prio_arb #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk      (CLK),
    .srst     (RST),
    .arb_en_i (arb_en),
    .m0_req_i (M0_REQ),
    .m1_req_i (M1_REQ),
    .m0_gnt_o (gnt0),
    .m1_gnt_o (gnt1)
  );

  assign M0_GNT = gnt0;
  assign M1_GNT = gnt1;

  // Memory-port mux and next-state: winner drives the port in IDLE, hold registers in RD_DATA.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sign_d    = sign_q;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    MEM_ADDR2 = '0;
    MEM_DIN2  = '0;
    MEM_SIZE  = SZ_BYTE;
    MEM_SIGN  = 1'b0;
    sel_req   = gnt1 ? m1_req : m0_req;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          MEM_ADDR2 = sel_req.addr;
          MEM_DIN2  = sel_req.din;
          MEM_SIZE  = sel_req.size;
          MEM_SIGN  = sel_req.sign;
          if (sel_req.we) begin
            MEM_WE2 = 1'b1;
          end else begin
            MEM_RDEN2 = 1'b1;
            owner_d   = gnt1;
            addr_d    = sel_req.addr;
            size_d    = sel_req.size;
            sign_d    = sel_req.sign;
            state_d   = RD_DATA;
          end
        end
      end
      RD_DATA: begin
        MEM_ADDR2 = addr_q;
        MEM_SIZE  = size_q;
        MEM_SIGN  = sign_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and load-hold registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
    end
  end

  // Per-port load return: capture DOUT2 at the end of RD_DATA into the owner's data register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    always_ff @(posedge CLK) begin
      if (RST) begin
        rvalid_q[gi] <= 1'b0;
        rdata_q[gi]  <= '0;
      end else begin
        rvalid_q[gi] <= (state_q == RD_DATA) && (owner_q == 1'(gi));
        if ((state_q == RD_DATA) && (owner_q == 1'(gi))) begin
          rdata_q[gi] <= MEM_DOUT2;
        end
      end
    end
  end

  assign M0_RVALID = rvalid_q[0];
  assign M1_RVALID = rvalid_q[1];
  assign M0_RDATA  = rdata_q[0];
  assign M1_RDATA  = rdata_q[1];

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Randomized bench for otter_dmem_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_otter_dmem_arbiter;
  import otter_mem_pkg::*;

  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pend;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } rq_t;

  logic rst;
  rq_t  rq [2];

  logic        M0_GNT, M1_GNT, M0_RVALID, M1_RVALID;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
  logic [1:0]  MEM_SIZE;

  otter_dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK(clk), .RST(rst),
    .M0_REQ(rq[0].pend), .M0_WE(rq[0].we), .M0_ADDR(rq[0].addr), .M0_DIN(rq[0].din),
    .M0_SIZE(rq[0].size), .M0_SIGN(rq[0].sign),
    .M1_REQ(rq[1].pend), .M1_WE(rq[1].we), .M1_ADDR(rq[1].addr), .M1_DIN(rq[1].din),
    .M1_SIZE(rq[1].size), .M1_SIGN(rq[1].sign),
    .M0_GNT(M0_GNT), .M1_GNT(M1_GNT), .M0_RVALID(M0_RVALID), .M1_RVALID(M1_RVALID),
    .M0_RDATA(M0_RDATA), .M1_RDATA(M1_RDATA),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
  );

  // Size/sign extraction of a byte lane group out of a 32-bit word (SIGN 1 = unsigned).
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Memory environment: synchronous word read at RDEN2, sized combinationally from the live port.
  logic [7:0]  env_mem [0:1023];
  logic [31:0] rd_word;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= 8'h00;
      rd_word <= '0;
    end else begin
      if (MEM_WE2) begin
        env_mem[MEM_ADDR2[9:0]] <= MEM_DIN2[7:0];
        if (MEM_SIZE != 2'd0) env_mem[MEM_ADDR2[9:0] + 10'd1] <= MEM_DIN2[15:8];
        if (MEM_SIZE == 2'd2) begin
          env_mem[MEM_ADDR2[9:0] + 10'd2] <= MEM_DIN2[23:16];
          env_mem[MEM_ADDR2[9:0] + 10'd3] <= MEM_DIN2[31:24];
        end
      end
      if (MEM_RDEN2) begin
        rd_word <= {env_mem[{MEM_ADDR2[9:2], 2'b11}], env_mem[{MEM_ADDR2[9:2], 2'b10}],
                    env_mem[{MEM_ADDR2[9:2], 2'b01}], env_mem[{MEM_ADDR2[9:2], 2'b00}]};
      end
    end
  end
  assign MEM_DOUT2 = load_ext(rd_word, MEM_ADDR2[1:0], MEM_SIZE, MEM_SIGN);

  // Reference model state.
  logic [7:0]  ref_mem [0:1023];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lose = 0;
  bit          busy = 0;
  logic [31:0] h_addr;
  logic [1:0]  h_size;
  logic        h_sign;
  int          due [2];
  logic [31:0] dval [2];
  logic [31:0] exp_rdata [2];
  int          last_gnt [2];
  bit          rand_en = 0;
  int          rate [2];
  bit          store_only [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
    ref_mem[a[9:0]] = d[7:0];
    if (size != 2'd0) ref_mem[a[9:0] + 10'd1] = d[15:8];
    if (size == 2'd2) begin
      ref_mem[a[9:0] + 10'd2] = d[23:16];
      ref_mem[a[9:0] + 10'd3] = d[31:24];
    end
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
    logic [31:0] w;
    w = {ref_mem[{a[9:2], 2'b11}], ref_mem[{a[9:2], 2'b10}],
         ref_mem[{a[9:2], 2'b01}], ref_mem[{a[9:2], 2'b00}]};
    return load_ext(w, a[1:0], size, uns);
  endfunction

  function automatic rq_t rand_req(input bit st_only);
    rq_t         r;
    logic [31:0] base;
    int          sz;
    r.pend = 1'b1;
    r.we   = st_only ? 1'b1 : 1'($urandom_range(1));
    base   = ($urandom_range(1) == 0) ? 32'h100 : (MMIO_BASE + 32'h200);
    sz     = int'($urandom_range(2));
    r.addr = base + 32'($urandom_range(63)) * 4;
    if (sz == 0) r.addr = r.addr + 32'($urandom_range(3));
    if (sz == 1) r.addr = r.addr + 32'($urandom_range(1)) * 2;
    r.size = 2'(sz);
    r.din  = $urandom();
    r.sign = 1'($urandom_range(1));
    return r;
  endfunction

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] size, input logic uns);
    rq[p] = '{pend: 1'b1, we: we, addr: a, din: d, size: size, sign: uns};
  endtask

  // One clock: generate requests, check the cycle at negedge, advance the model at the edge.
  task automatic cycle();
    int          win;
    logic        e_we, e_rd, e_sign, got_rv;
    logic [31:0] e_addr, e_din;
    logic [1:0]  e_size;
    for (int p = 0; p < 2; p++)
      if (rand_en && !rq[p].pend && ($urandom_range(99) < 32'(rate[p]))) rq[p] = rand_req(store_only[p]);
    @(negedge clk);
    win = -1;
    if (!rst && !busy) begin
      if (rq[1].pend && (!rq[0].pend || lose >= MAX_WAIT)) win = 1;
      else if (rq[0].pend) win = 0;
    end
    if (M0_GNT) last_gnt[0] = cyc;
    if (M1_GNT) last_gnt[1] = cyc;
    e_we = 1'b0; e_rd = 1'b0; e_addr = '0; e_din = '0; e_size = 2'd0; e_sign = 1'b0;
    if (win >= 0) begin
      e_we = rq[win].we; e_rd = !rq[win].we;
      e_addr = rq[win].addr; e_din = rq[win].din; e_size = rq[win].size; e_sign = rq[win].sign;
    end else if (busy) begin
      e_addr = h_addr; e_size = h_size; e_sign = h_sign;
    end
    check("m0_gnt", M0_GNT, win == 0);
    check("m1_gnt", M1_GNT, win == 1);
    check("mem_we2", MEM_WE2, e_we);
    check("mem_rden2", MEM_RDEN2, e_rd);
    if (!rst) begin
      check("mem_addr2", MEM_ADDR2, e_addr);
      check("mem_din2", MEM_DIN2, e_din);
      check("mem_size", MEM_SIZE, e_size);
      check("mem_sign", MEM_SIGN, e_sign);
    end
    for (int p = 0; p < 2; p++) begin
      if (due[p] == cyc) exp_rdata[p] = dval[p];
      got_rv = (p == 0) ? M0_RVALID : M1_RVALID;
      check($sformatf("m%0d_rvalid", p), got_rv, due[p] == cyc);
      check($sformatf("m%0d_rdata", p), (p == 0) ? M0_RDATA : M1_RDATA, exp_rdata[p]);
    end
    if (rst) begin
      busy = 0; lose = 0;
      for (int p = 0; p < 2; p++) begin due[p] = -1; exp_rdata[p] = '0; end
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    end else if (busy) begin
      busy = 0;
    end else begin
      if (win >= 0) begin
        if (rq[win].we) begin
          ref_store(rq[win].addr, rq[win].size, rq[win].din);
        end else begin
          due[win]  = cyc + 2;
          dval[win] = ref_load(rq[win].addr, rq[win].size, rq[win].sign);
          h_addr = rq[win].addr; h_size = rq[win].size; h_sign = rq[win].sign;
          busy = 1;
        end
      end
      if (rq[1].pend && win != 1) begin
        if (lose < MAX_WAIT) lose++;
      end else begin
        lose = 0;
      end
    end
    @(posedge clk);
    #1;
    if (win >= 0) rq[win].pend = 1'b0;
    cyc++;
  endtask

  task automatic drain();
    int   n;
    logic done;
    n = 0;
    while ((rq[0].pend || rq[1].pend || busy || due[0] >= cyc || due[1] >= cyc) && n < 80) begin
      cycle();
      n++;
    end
    done = !(rq[0].pend || rq[1].pend || busy || due[0] >= cyc || due[1] >= cyc);
    check("drain_done", done, 1'b1);
  endtask

  initial begin
    int s;
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rq[p] = '0; due[p] = -1; dval[p] = '0; exp_rdata[p] = '0; last_gnt[p] = -1;
      rate[p] = 0; store_only[p] = 0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    repeat (3) cycle();
    rst = 1'b0;

    // Store then load back the same word.
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF, SZ_WORD, 1'b0);
    drain();
    issue(0, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0);
    drain();
    check("store_load_rdata", M0_RDATA, 32'hDEADBEEF);

    // Signed and unsigned byte loads rely on the address being held through RD_DATA.
    issue(0, 1'b1, 32'h103, 32'h0000_0080, SZ_BYTE, 1'b0);
    drain();
    issue(0, 1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b0);
    drain();
    check("hold_signed_byte", M0_RDATA, 32'hFFFF_FF80);
    issue(1, 1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b1);
    drain();
    check("hold_unsigned_byte", M1_RDATA, 32'h0000_0080);

    // Simultaneous loads: M0 first, M1 at the next arbitration two cycles later.
    issue(0, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0);
    issue(1, 1'b0, 32'h102, 32'h0, SZ_HALF, 1'b1);
    drain();
    check("simul_order", last_gnt[1] - last_gnt[0], 2);
    check("simul_m0", M0_RDATA, 32'h80AD_BEEF);
    check("simul_m1", M1_RDATA, 32'h0000_80AD);

    // Starvation guard, twice in a row so the counter must restart from zero.
    for (int rep = 0; rep < 2; rep++) begin
      rand_en = 1; rate[0] = 100; store_only[0] = 1; rate[1] = 0;
      repeat (2) cycle();
      s = cyc;
      last_gnt[1] = -1;
      issue(1, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0);
      for (int i = 0; i < 20 && last_gnt[1] < 0; i++) cycle();
      check("starve_wait", last_gnt[1] - s, MAX_WAIT);
      rand_en = 0; rate[0] = 0; store_only[0] = 0;
      drain();
    end

    // Reset during RD_DATA drops the read and clears the data registers.
    issue(0, 1'b1, 32'h100, 32'h1234_5678, SZ_WORD, 1'b0);
    issue(1, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0);
    drain();
    check("pre_rst_m1", M1_RDATA, 32'h1234_5678);
    issue(0, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    check("rst_m0_rdata", M0_RDATA, 32'h0);
    check("rst_m1_rdata", M1_RDATA, 32'h0);

    // MMIO store and read-back through M1.
    issue(1, 1'b1, 32'h1100_0000, 32'hCAFE_F00D, SZ_WORD, 1'b0);
    cycle();
    issue(1, 1'b0, 32'h1100_0000, 32'h0, SZ_WORD, 1'b0);
    drain();
    check("mmio_readback", M1_RDATA, 32'hCAFE_F00D);

    // Random traffic with occasional resets.
    rand_en = 1; rate[0] = 35; rate[1] = 35;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(199) == 0);
      cycle();
    end
    rst = 1'b0;
    rand_en = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_dmem_arbiter.md
Name: otter_dmem_arbiter

Overview:
Shares the OTTER memory data port (RDEN2/WE2/ADDR2/DIN2/SIZE/SIGN -> DOUT2) between two requesters: M0 = CPU load/store unit, M1 = DMA/program loader.
The block sequences the memory's synchronous-read protocol. It holds address, size and sign stable through the data-return cycle, because the memory sizes and sign-extends DOUT2 combinationally from them.
Arbitration is fixed priority to M0, with a starvation guard for M1.

Parameters:
MAX_WAIT, 4, consecutive cycles M1 may request and lose before it wins the next arbitration (>=1)

Ports:
CLK  in  1  system clock; single clock domain
RST  in  1  reset, synchronous, active-high
M0_REQ / M1_REQ  in  1 each  request valid; requester holds it and all attributes until GNT
M0_WE / M1_WE  in  1 each  1 = store, 0 = load
M0_ADDR / M1_ADDR  in  32 each  byte address; >= 0x00010000 is MMIO, passed through unchanged
M0_DIN / M1_DIN  in  32 each  store data
M0_SIZE / M1_SIZE  in  2 each  0 byte, 1 half, 2 word
M0_SIGN / M1_SIGN  in  1 each  1 unsigned, 0 signed
M0_GNT / M1_GNT  out  1 each  request accepted this cycle (combinational)
M0_RVALID / M1_RVALID  out  1 each  one-cycle pulse, load data valid (registered)
M0_RDATA / M1_RDATA  out  32 each  load data, held until the next RVALID for that port
MEM_RDEN2, MEM_WE2  out  1 each  to memory
MEM_ADDR2, MEM_DIN2  out  32 each  to memory
MEM_SIZE  out  2  to memory
MEM_SIGN  out  1  to memory
MEM_DOUT2  in  32  sized and extended read data from memory

Behaviour:
- States: IDLE, RD_DATA.
- IDLE, arbitration:
  - winner = M1 if M1_REQ and (!M0_REQ or wait_cnt == MAX_WAIT); else M0 if M0_REQ; else none.
  - Winner's GNT = 1. Winner's ADDR/DIN/SIZE/SIGN drive MEM_* combinationally.
  - Winner WE = 1 -> MEM_WE2 = 1 for that one cycle; store complete; stay IDLE.
  - Winner WE = 0 -> MEM_RDEN2 = 1; latch owner, ADDR, SIZE, SIGN into hold registers; go RD_DATA.
  - No winner -> MEM_RDEN2 = MEM_WE2 = 0; MEM_ADDR2/DIN2/SIZE/SIGN = 0.
- RD_DATA, exactly one cycle:
  - MEM_ADDR2/SIZE/SIGN driven from hold registers; MEM_RDEN2 = MEM_WE2 = 0; MEM_DIN2 = 0.
  - Both GNT = 0.
  - At clock edge: capture MEM_DOUT2 into owner's RDATA, pulse owner's RVALID next cycle, go IDLE.
- Latency:
  - Load: GNT in cycle T, RVALID and RDATA at T+2.
  - Store: accepted and written at edge ending T.
  - New grant permitted at T+2, concurrent with RVALID. Peak rate: one store per cycle, one load per two cycles.
- wait_cnt, width clog2(MAX_WAIT+1):
  - Increments when M1_REQ is high and M1 not granted in IDLE; saturates at MAX_WAIT.
  - Holds during RD_DATA.
  - Clears when M1 is granted or M1_REQ is low in IDLE.
- Simultaneous REQ with wait_cnt < MAX_WAIT -> M0 wins.
- MMIO addresses arbitrated identically; the memory's IO read buffer is loaded at RDEN2, so the same 2-cycle timing applies.
- RST high at a clock edge:
  - State -> IDLE; wait_cnt, hold registers, RVALIDs, RDATAs -> 0.
  - An in-flight read is dropped with no RVALID.
  - While RST is high, GNT, MEM_RDEN2 and MEM_WE2 are forced to 0.
- GNT depends on REQ combinationally. No output depends combinationally on MEM_DOUT2.

Decomposition:
- Package otter_mem_pkg: typedef enum for size {SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2}; localparam MMIO_BASE = 32'h00010000; typedef struct mem_req_t {we, addr, din, size, sign}; typedef enum arb_state_t {IDLE, RD_DATA}.
- One natural sub-module: dmem_prio_arb, combinational winner selection plus the wait_cnt register.

Test Plan:
- Store only: M0 store, WE = 1, ADDR 0x100, DIN 0xDEADBEEF, SIZE 2 -> M0_GNT and MEM_WE2 high same cycle, MEM_ADDR2 = 0x100; a later M0 load of 0x100 gives M0_RDATA = 0xDEADBEEF, RVALID 2 cycles after GNT.
- Address hold: M0 signed byte load at 0x103 holding 0x80 -> MEM_ADDR2 stays 0x103, SIZE 0, SIGN 0 through RD_DATA; M0_RDATA = 0xFFFFFF80.
- Simultaneous requests: M0 and M1 load together, wait_cnt = 0 -> M0 granted first; M1 granted at the next IDLE cycle; each RVALID hits only its own port.
- Starvation, MAX_WAIT = 4: M0 issues back-to-back stores every cycle, M1_REQ high throughout -> M1_GNT on the 5th cycle; wait_cnt resets to 0.
- Reset mid-read: RST asserted in RD_DATA -> no M*_RVALID, MEM_RDEN2 = 0, state IDLE, RDATA = 0.
- MMIO store: M1 store to 0x11000000 -> MEM_WE2 = 1 with MEM_ADDR2 = 0x11000000 for one cycle.
